// File: rtl/cu_cacheline_read_cmd_gen.sv
// One job (base + element count) becomes one 128B read command per touched cacheline, tagged with CU_ID.
// Accept at T -> first command at T+2; commands hold under cmd_ready_in low and stall when credits run out.
module cu_cacheline_read_cmd_gen #(
    parameter logic [7:0] CU_ID           = 8'hFC,
    parameter int         CACHELINE_SIZE  = 128,
    parameter int         ARRAY_SIZE      = 4,
    parameter int         MAX_OUTSTANDING = 8
) (
    input  logic        clock,
    input  logic        rstn,
    input  logic        enabled_in,
    input  logic        job_valid_in,
    input  logic [0:63] job_base_addr_in,
    input  logic [31:0] job_num_elem_in,
    output logic        job_ready_out,
    output logic        cmd_valid_out,
    input  logic        cmd_ready_in,
    output logic [63:0] cmd_address_out,
    output logic [7:0]  cmd_cu_id_out,
    output logic [31:0] cmd_cl_index_out,
    input  logic        rsp_done_in,
    output logic [7:0]  outstanding_out,
    output logic        done_out,
    output logic        error_out
);
    typedef enum logic [2:0] {IDLE, CALC, ISSUE, DRAIN, DONE} state_t;

    localparam int          CL_SHIFT = $clog2(CACHELINE_SIZE);
    localparam logic [63:0] CL_STEP  = 64'(CACHELINE_SIZE);
    localparam logic [63:0] CL_MASK  = ~(CL_STEP - 64'd1);
    localparam logic [7:0]  MAX_CRED = 8'(MAX_OUTSTANDING);

    state_t      state_q, state_d;
    logic [63:0] base_q, base_d;
    logic [63:0] addr_q, addr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] index_q, index_d;
    logic [31:0] remaining_q, remaining_d;
    logic [7:0]  credits_q, credits_d;
    logic        error_q, error_d;

    logic        fire;
    logic        rsp_ok;
    logic [33:0] bytes;
    logic [63:0] first_cl;
    logic [63:0] last_cl;
    logic [63:0] span;

    assign cmd_valid_out    = (state_q == ISSUE) && (remaining_q != 32'd0) && (credits_q != 8'd0);
    assign fire             = cmd_valid_out && cmd_ready_in;
    assign rsp_ok           = rsp_done_in && (credits_q != MAX_CRED);
    assign job_ready_out    = (state_q == IDLE) && enabled_in && rstn;
    assign done_out         = (state_q == DONE);
    assign error_out        = error_q;
    assign cmd_address_out  = addr_q;
    assign cmd_cl_index_out = index_q;
    assign cmd_cu_id_out    = CU_ID;
    assign outstanding_out  = MAX_CRED - credits_q;

    // Widened multiply so large element counts never truncate the byte span.
    assign bytes    = 34'(count_q) * 34'(ARRAY_SIZE);
    assign first_cl = base_q & CL_MASK;
    assign last_cl  = (base_q + 64'(bytes) - 64'd1) & CL_MASK;
    assign span     = last_cl - first_cl;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        addr_d      = addr_q;
        count_d     = count_q;
        index_d     = index_q;
        remaining_d = remaining_q;
        // A response with nothing outstanding is flagged and does not overfill the pool.
        credits_d   = credits_q - {7'd0, fire} + {7'd0, rsp_ok};
        error_d     = error_q | (rsp_done_in && (credits_q == MAX_CRED));

        case (state_q)
            IDLE: begin
                if (job_ready_out && job_valid_in) begin
                    base_d  = job_base_addr_in;
                    count_d = job_num_elem_in;
                    state_d = CALC;
                end
            end
            CALC: begin
                addr_d  = first_cl;
                index_d = 32'd0;
                if (count_q == 32'd0) begin
                    remaining_d = 32'd0;
                    state_d     = DRAIN;
                end else begin
                    remaining_d = 32'(span >> CL_SHIFT) + 32'd1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (fire) begin
                    addr_d      = addr_q + CL_STEP;
                    index_d     = index_q + 32'd1;
                    remaining_d = remaining_q - 32'd1;
                    if (remaining_q == 32'd1) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (credits_q == MAX_CRED) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rstn) begin
            state_q     <= IDLE;
            base_q      <= 64'd0;
            addr_q      <= 64'd0;
            count_q     <= 32'd0;
            index_q     <= 32'd0;
            remaining_q <= 32'd0;
            credits_q   <= MAX_CRED;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            index_q     <= index_d;
            remaining_q <= remaining_d;
            credits_q   <= credits_d;
            error_q     <= error_d;
        end
    end
endmodule

// File: tb/tb_cu_cacheline_read_cmd_gen.sv
// Randomized bench for cu_cacheline_read_cmd_gen against a job-level model (line count, issue window, credits).
module tb_cu_cacheline_read_cmd_gen;
    logic        clock = 1'b0;
    logic        rstn = 1'b0;
    logic        enabled_in = 1'b0;
    logic        job_valid_in = 1'b0;
    logic [0:63] job_base_addr_in = '0;
    logic [31:0] job_num_elem_in = '0;
    logic        job_ready_out;
    logic        cmd_valid_out;
    logic        cmd_ready_in = 1'b0;
    logic [63:0] cmd_address_out;
    logic [7:0]  cmd_cu_id_out;
    logic [31:0] cmd_cl_index_out;
    logic        rsp_done_in = 1'b0;
    logic [7:0]  outstanding_out;
    logic        done_out;
    logic        error_out;

    always #5 clock = ~clock;

    cu_cacheline_read_cmd_gen dut (
        .clock(clock), .rstn(rstn), .enabled_in(enabled_in),
        .job_valid_in(job_valid_in), .job_base_addr_in(job_base_addr_in),
        .job_num_elem_in(job_num_elem_in), .job_ready_out(job_ready_out),
        .cmd_valid_out(cmd_valid_out), .cmd_ready_in(cmd_ready_in),
        .cmd_address_out(cmd_address_out), .cmd_cu_id_out(cmd_cu_id_out),
        .cmd_cl_index_out(cmd_cl_index_out), .rsp_done_in(rsp_done_in),
        .outstanding_out(outstanding_out), .done_out(done_out), .error_out(error_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Lines touched = ceil((offset within first line + bytes) / 128).
    function automatic longint unsigned lines_for(input logic [63:0] base, input logic [31:0] cnt);
        longint unsigned bytes;
        bytes = longint'(cnt) * 4;
        if (cnt == 0) return 0;
        return ((base % 128) + bytes + 127) / 128;
    endfunction

    // Model state, as seen during the current cycle
    bit              m_active = 0;
    int              m_acc = -10;
    longint unsigned m_n = 0;
    longint unsigned m_issued = 0;
    logic [63:0]     m_first = '0;
    int              m_outst = 0;
    bit              m_err = 0;
    bit              m_pend_done = 0;
    int              cyc = 0;

    // Independent observations of the DUT for directed literal checks
    int dut_fires = 0;
    int dut_done_cyc = -1;
    int dut_peak = 0;

    initial begin : compare
        bit          exp_v, fire, done_now, p_hold;
        logic [63:0] p_addr;
        logic [31:0] p_idx;
        logic [63:0] base;
        p_hold = 0;
        p_addr = '0;
        p_idx = '0;
        @(posedge clock);
        forever begin
            @(negedge clock);
            exp_v = m_active && (cyc >= m_acc + 2) && (m_issued < m_n) && (m_outst < 8);
            check("cmd_valid", {63'd0, cmd_valid_out}, {63'd0, exp_v});
            if (exp_v) begin
                check("cmd_address", cmd_address_out, m_first + 64'(m_issued) * 64'd128);
                check("cmd_index", {32'd0, cmd_cl_index_out}, 64'(m_issued));
            end
            check("cu_id", {56'd0, cmd_cu_id_out}, 64'hFC);
            check("outstanding", {56'd0, outstanding_out}, 64'(m_outst));
            check("done", {63'd0, done_out}, {63'd0, m_active && m_pend_done});
            check("error", {63'd0, error_out}, {63'd0, m_err});
            check("job_ready", {63'd0, job_ready_out}, {63'd0, !m_active && enabled_in && rstn});
            if (p_hold) begin
                check("hold_valid", {63'd0, cmd_valid_out}, 64'd1);
                check("hold_addr", cmd_address_out, p_addr);
                check("hold_index", {32'd0, cmd_cl_index_out}, {32'd0, p_idx});
            end
            p_hold = rstn && cmd_valid_out && !cmd_ready_in;
            p_addr = cmd_address_out;
            p_idx  = cmd_cl_index_out;
            if (cmd_valid_out && cmd_ready_in) dut_fires++;
            if (done_out) dut_done_cyc = cyc;
            if (int'(outstanding_out) > dut_peak) dut_peak = int'(outstanding_out);

            // Advance the model across the coming clock edge
            fire = exp_v && cmd_ready_in;
            if (!rstn) begin
                m_active = 0;
                m_outst = 0;
                m_err = 0;
                m_pend_done = 0;
            end else begin
                if (rsp_done_in && m_outst == 0) m_err = 1;
                done_now = m_active && m_pend_done;
                m_pend_done = m_active && !done_now && (cyc >= m_acc + 2) &&
                              (m_issued == m_n) && (m_outst == 0);
                m_outst = m_outst + (fire ? 1 : 0) - ((rsp_done_in && m_outst > 0) ? 1 : 0);
                if (fire) m_issued++;
                if (done_now) begin
                    m_active = 0;
                end else if (!m_active && job_valid_in && enabled_in) begin
                    base = job_base_addr_in;
                    m_active = 1;
                    m_acc = cyc;
                    m_n = lines_for(base, job_num_elem_in);
                    m_first = base & ~64'd127;
                    m_issued = 0;
                    dut_fires = 0;
                    dut_peak = 0;
                    dut_done_cyc = -1;
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_cycles(input int n, input int rdy, input int rsp);
        repeat (n) begin
            cmd_ready_in = ($urandom_range(0, 99) < rdy);
            rsp_done_in  = (m_outst > 0) && ($urandom_range(0, 99) < rsp);
            enabled_in   = 1'($urandom_range(0, 1));
            tick();
        end
        rsp_done_in = 1'b0;
    endtask

    task automatic start_job(input logic [63:0] base, input logic [31:0] cnt);
        int i;
        enabled_in = 1'b1;
        rsp_done_in = 1'b0;
        cmd_ready_in = 1'b1;
        job_base_addr_in = base;
        job_num_elem_in = cnt;
        job_valid_in = 1'b1;
        for (i = 0; i < 20; i++) begin
            tick();
            if (m_active) break;
        end
        job_valid_in = 1'b0;
        check("job_accepted", {63'd0, m_active}, 64'd1);
    endtask

    task automatic wait_idle(input int rdy, input int rsp, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (!m_active) break;
            run_cycles(1, rdy, rsp);
        end
        check("job_complete", {63'd0, m_active}, 64'd0);
    endtask

    initial begin : timeout
        #5_000_000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [63:0] b;
        logic [31:0] c;
        int          acc;
        // Pin the line-count model with hand-computed values
        check("model_lines_aligned", lines_for(64'h1000, 32), 64'd1);
        check("model_lines_straddle", lines_for(64'h1004, 32), 64'd2);
        check("model_lines_zero", lines_for(64'h1000, 0), 64'd0);
        check("model_lines_100", lines_for(64'h0, 3200), 64'd100);
        check("model_lines_wrap", lines_for(64'hFFFF_FFFF_FFFF_FFF0, 8), 64'd2);

        repeat (3) tick();
        rstn = 1'b1;
        tick();

        // Single aligned line, responses trickle back
        start_job(64'h1000, 32);
        wait_idle(100, 30, 200);
        check("t1_fires", 64'(dut_fires), 64'd1);

        // Two lines, outstanding reaches 2
        start_job(64'h1004, 32);
        run_cycles(4, 100, 0);
        wait_idle(100, 40, 200);
        check("t2_fires", 64'(dut_fires), 64'd2);
        check("t2_peak", 64'(dut_peak), 64'd2);

        // Zero-length job: done exactly 3 cycles after acceptance
        start_job(64'h1234, 0);
        acc = m_acc;
        wait_idle(100, 0, 20);
        check("t3_fires", 64'(dut_fires), 64'd0);
        check("t3_done_latency", 64'(dut_done_cyc - acc), 64'd3);

        // Credit exhaustion: 8 commands, then one response buys exactly one more
        start_job(64'h2000, 3200);
        run_cycles(40, 100, 0);
        check("t4_fires_stalled", 64'(dut_fires), 64'd8);
        check("t4_outstanding_full", {56'd0, outstanding_out}, 64'd8);
        cmd_ready_in = 1'b1;
        rsp_done_in = 1'b1;
        tick();
        rsp_done_in = 1'b0;
        run_cycles(10, 100, 0);
        check("t4_fires_after_rsp", 64'(dut_fires), 64'd9);
        wait_idle(100, 60, 3000);
        check("t4_fires_total", 64'(dut_fires), 64'd100);

        // Backpressure: command held while ready is low
        start_job(64'h3000, 64);
        run_cycles(6, 0, 0);
        check("t5_no_fire_while_held", 64'(dut_fires), 64'd0);
        wait_idle(100, 50, 200);
        check("t5_fires", 64'(dut_fires), 64'd2);

        // Randomized jobs, including address wrap near the top of memory
        for (int j = 0; j < 40; j++) begin
            if ($urandom_range(0, 7) == 0) b = {32'hFFFF_FFFF, $urandom | 32'hFFFF_F000};
            else b = {$urandom, $urandom};
            c = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 600));
            start_job(b, c);
            wait_idle($urandom_range(30, 100), $urandom_range(20, 90), 20000);
        end

        // Reset mid-issue, then a spurious response in IDLE
        start_job(64'h4000, 1000);
        for (int i = 0; i < 50 && m_issued < 3; i++) run_cycles(1, 100, 0);
        cmd_ready_in = 1'b1;
        rstn = 1'b0;
        tick();
        check("t6_valid_in_reset", {63'd0, cmd_valid_out}, 64'd0);
        check("t6_outstanding_in_reset", {56'd0, outstanding_out}, 64'd0);
        check("t6_ready_in_reset", {63'd0, job_ready_out}, 64'd0);
        check("t6_done_in_reset", {63'd0, done_out}, 64'd0);
        rstn = 1'b1;
        enabled_in = 1'b1;
        tick();
        check("t6_ready_after_reset", {63'd0, job_ready_out}, 64'd1);
        rsp_done_in = 1'b1;
        tick();
        rsp_done_in = 1'b0;
        tick();
        check("t6_error_set", {63'd0, error_out}, 64'd1);
        repeat (5) tick();
        check("t6_error_sticky", {63'd0, error_out}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
